// File: rtl/flash_sequencer.sv
// ---------------------------------------------------------------------------
// flash_sequencer
//
// Plays the current colour sequence back on the LEDs, one colour at a time.
// It sits between the game FSM and the flash datapath. It steps the
// segment-array read index, gates the one-hot LED drive, programs the flash
// timer speed from the round length, and paces the lit and blank phases
// from the timer tick.
//
// Optional feature macro: FLASH_SEQ_REPLAY_EN
//   When defined, this adds a 'replay' input. Replay restarts playback using
//   the last latched length.
//
// Ports:
//   clk        in   system clock
//   reset_n    in   synchronous reset, active-low
//   start      in   begin playback (sampled only in IDLE)
//   abort      in   cancel playback, return to IDLE without done
//   replay     in   (FLASH_SEQ_REPLAY_EN only) replay last length
//   round_len  in   [5:0] number of colours to play, sampled at start
//   colour_i   in   [1:0] segment[seg_idx], combinational from segment array
//   tick       in   one-cycle pulse from the flash timer
//   seg_idx    out  [5:0] segment read index
//   disp_o     out  [3:0] one-hot LED drive, 0 when blank
//   speed      out  [2:0] timer speed code
//   load_speed out  one-cycle reload strobe to the timer
//   busy       out  high in every state but IDLE
//   done       out  one-cycle pulse when playback completes
// ---------------------------------------------------------------------------
module flash_sequencer #(
   parameter int MAX_LEN    = 33,
   parameter int ON_TICKS   = 2,
   parameter int OFF_TICKS  = 1,
   parameter int SPEED_STEP = 8,
   parameter int MAX_SPEED  = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       abort,
`ifdef FLASH_SEQ_REPLAY_EN
   input  logic       replay,
`endif
   input  logic [5:0] round_len,
   input  logic [1:0] colour_i,
   input  logic       tick,
   output logic [5:0] seg_idx,
   output logic [3:0] disp_o,
   output logic [2:0] speed,
   output logic       load_speed,
   output logic       busy,
   output logic       done
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] LOAD = 3'd1;
   localparam logic [2:0] ON   = 3'd2;
   localparam logic [2:0] OFF  = 3'd3;
   localparam logic [2:0] FIN  = 3'd4;

   localparam int TICK_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
   localparam int CNT_W    = $clog2(TICK_MAX + 1);

   localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_TICKS - 1);
   localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'((OFF_TICKS > 0) ? OFF_TICKS - 1 : 0);
   localparam bit               HAS_GAP  = (OFF_TICKS > 0);

   localparam logic [5:0] LEN_CAP = 6'(MAX_LEN);
   localparam logic [5:0] STEP    = 6'(SPEED_STEP);
   localparam logic [5:0] SPD_CAP = 6'(MAX_SPEED);

   // Every SPEED_STEP colours raise the speed code by one level, up to a cap.
   // STEP is a constant divisor, so synthesis reduces this to a shift or a
   // small constant divider.
   function automatic logic [2:0] speed_of(input logic [5:0] len);
      logic [5:0] level;
      level = (len - 6'd1) / STEP;
      if (len == 6'd0)     return 3'd0;
      if (level > SPD_CAP) return SPD_CAP[2:0];
      return level[2:0];
   endfunction

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [5:0]       len_q, len_d;
   logic [5:0]       idx_d;
   logic [2:0]       speed_d;
   logic [5:0]       sel_len;
   logic             go;
   logic             at_last;

   assign at_last = (seg_idx == len_q - 6'd1);

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no branch can leave it unassigned and infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      idx_d   = seg_idx;
      speed_d = speed;
      sel_len = (round_len > LEN_CAP) ? LEN_CAP : round_len;
      go      = start;
`ifdef FLASH_SEQ_REPLAY_EN
      // Replay reuses the last latched length. Start still wins over replay.
      if (!start && replay) begin
         sel_len = len_q;
         go      = 1'b1;
      end
`endif

      case (state_q)
         IDLE: begin
            if (go) begin
               len_d   = sel_len;
               speed_d = speed_of(sel_len);
               idx_d   = 6'd0;
               state_d = LOAD;
            end
         end
         LOAD: begin
            cnt_d   = '0;
            idx_d   = 6'd0;
            state_d = (len_q == 6'd0) ? FIN : ON;
         end
         ON: begin
            if (tick) begin
               if (cnt_q == ON_LAST) begin
                  cnt_d = '0;
                  if (HAS_GAP)      state_d = OFF;
                  else if (at_last) state_d = FIN;
                  else begin
                     idx_d   = seg_idx + 6'd1;
                     state_d = ON;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         OFF: begin
            if (tick) begin
               if (cnt_q == OFF_LAST) begin
                  cnt_d = '0;
                  if (at_last) state_d = FIN;
                  else begin
                     idx_d   = seg_idx + 6'd1;
                     state_d = ON;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Abort overrides tick and start everywhere except IDLE.
      if (abort && state_q != IDLE) begin
         state_d = IDLE;
         idx_d   = 6'd0;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments make every register sample pre-edge values, independent of statement order.
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         len_q   <= 6'd0;
         seg_idx <= 6'd0;
         speed   <= 3'd0;
         disp_o  <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         seg_idx <= idx_d;
         speed   <= speed_d;
         // Drive the colour only while staying in ON. This blanks the LEDs on
         // the edge that leaves ON for OFF, FIN or IDLE. With no gap, the
         // old colour is held for one cycle while the next index is read.
         disp_o  <= (state_q == ON && state_d == ON) ? (4'b0001 << colour_i) : 4'b0000;
      end
   end

   assign busy       = (state_q != IDLE);
   assign load_speed = (state_q == LOAD);
   assign done       = (state_q == FIN);

endmodule

// File: tb/tb_flash_sequencer.sv
// ---------------------------------------------------------------------------
// tb_flash_sequencer
//
// Self-checking bench for flash_sequencer.
//
// The stimulus process pushes the expected playback events into a queue.
// A negedge monitor turns DUT activity into events and compares each one
// against the head of the queue. The events are:
//   - a load_speed strobe, with its speed code;
//   - the end of each lit phase, with its index, colour, ticks lit and the
//     next LED value;
//   - a done pulse, with its last index and the busy level on the following
//     cycle.
// A second instance, built with OFF_TICKS=0, covers the no-gap boundary.
// Ticks arrive every 4 cycles, counted from each start.
// ---------------------------------------------------------------------------
module tb_flash_sequencer;

   typedef enum logic [1:0] {EV_NONE, EV_LOAD, EV_LIT, EV_DONE} ev_kind_t;
   typedef struct packed {
      ev_kind_t    kind;
      logic [23:0] data;
   } ev_t;

   logic       clk;
   logic       reset_n, start, abort, tick;
   logic [5:0] round_len;
   logic [1:0] colour;
   logic [5:0] seg_idx;
   logic [3:0] disp;
   logic [2:0] speed;
   logic       load_speed, busy, done;

   logic       start_ng, abort_ng;
   logic [1:0] colour_ng;
   logic [5:0] seg_idx_ng;
   logic [3:0] disp_ng;
   logic [2:0] speed_ng;
   logic       load_ng, busy_ng, done_ng;
`ifdef FLASH_SEQ_REPLAY_EN
   logic       replay, replay_ng;
`endif

   logic [1:0] seg_mem [64];
   assign colour    = seg_mem[seg_idx];
   assign colour_ng = seg_mem[seg_idx_ng];

   int  total = 0;
   int  bad   = 0;
   int  tcnt  = 0;
   ev_t exp_q [$];

   logic [3:0] m_prev     = 4'd0;
   logic [5:0] m_idx      = 6'd0;
   logic [3:0] m_ticks    = 4'd0;
   logic       m_done_d   = 1'b0;
   logic [5:0] m_done_idx = 6'd0;

   flash_sequencer dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .abort      (abort),
`ifdef FLASH_SEQ_REPLAY_EN
      .replay     (replay),
`endif
      .round_len  (round_len),
      .colour_i   (colour),
      .tick       (tick),
      .seg_idx    (seg_idx),
      .disp_o     (disp),
      .speed      (speed),
      .load_speed (load_speed),
      .busy       (busy),
      .done       (done)
   );

   flash_sequencer #(.OFF_TICKS(0)) dut_ng (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start_ng),
      .abort      (abort_ng),
`ifdef FLASH_SEQ_REPLAY_EN
      .replay     (replay_ng),
`endif
      .round_len  (round_len),
      .colour_i   (colour_ng),
      .tick       (tick),
      .seg_idx    (seg_idx_ng),
      .disp_o     (disp_ng),
      .speed      (speed_ng),
      .load_speed (load_ng),
      .busy       (busy_ng),
      .done       (done_ng)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", name, got, want);
      end
   endtask

   function automatic ev_t mk(input ev_kind_t k, input logic [23:0] d);
      ev_t e;
      e.kind = k;
      e.data = d;
      return e;
   endfunction

   function automatic logic [3:0] onehot(input logic [1:0] c);
      case (c)
         2'd0:    return 4'b0001;
         2'd1:    return 4'b0010;
         2'd2:    return 4'b0100;
         default: return 4'b1000;
      endcase
   endfunction

   function automatic logic [23:0] lit_word(input logic [5:0] idx, input logic [3:0] d,
                                            input logic [3:0] ticks, input logic [3:0] nxt);
      return {6'd0, idx, d, ticks, nxt};
   endfunction

   function automatic string name_of(input ev_kind_t k);
      case (k)
         EV_LOAD: return "load_speed_event";
         EV_LIT:  return "lit_phase_event";
         EV_DONE: return "done_event";
         default: return "unknown_event";
      endcase
   endfunction

   task automatic emit(input ev_t got);
      ev_t want;
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL unexpected_event: got kind=%0d data=%0h want none", got.kind, got.data);
      end else begin
         want = exp_q.pop_front();
         check(name_of(want.kind), {6'd0, got}, {6'd0, want});
      end
   endtask

   // Monitor: converts DUT activity into events, sampled on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (m_done_d) emit(mk(EV_DONE, {17'd0, m_done_idx, busy}));
         m_done_d   = (done === 1'b1);
         m_done_idx = seg_idx;
         if (load_speed === 1'b1) emit(mk(EV_LOAD, {21'd0, speed}));
         if (disp !== m_prev) begin
            if (m_prev != 4'd0) emit(mk(EV_LIT, lit_word(m_idx, m_prev, m_ticks, disp)));
            m_idx   = seg_idx;
            m_ticks = 4'd0;
         end
         if (disp != 4'd0 && tick === 1'b1) m_ticks = m_ticks + 4'd1;
         m_prev = disp;
      end
   end

   // Advance one clock and set inputs for the next edge. Ticks land on every
   // 4th edge after a start.
   task automatic step();
      @(posedge clk);
      #1;
      tcnt++;
      tick = (tcnt % 4 == 0);
   endtask

   task automatic expect_play(input int len, input logic [2:0] spd);
      logic [5:0] last;
      exp_q.push_back(mk(EV_LOAD, {21'd0, spd}));
      for (int i = 0; i < len; i++)
         exp_q.push_back(mk(EV_LIT, lit_word(6'(i), onehot(seg_mem[i]), 4'd2, 4'd0)));
      last = (len == 0) ? 6'd0 : 6'(len - 1);
      exp_q.push_back(mk(EV_DONE, {17'd0, last, 1'b0}));
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while ((busy !== 1'b0 || exp_q.size() != 0) && n < budget) begin
         step();
         n++;
      end
      check({name, "_completes"}, 32'(n < budget), 32'd1);
   endtask

   task automatic play(input logic [5:0] rl, input int len, input logic [2:0] spd, input string name);
      round_len = rl;
      start     = 1'b1;
      tcnt      = 0;
      tick      = 1'b0;
      expect_play(len, spd);
      step();
      start = 1'b0;
      wait_idle(name, 600);
   endtask

   initial begin
      logic [3:0] seen [$];
      int         done_cnt;

      reset_n   = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      tick      = 1'b0;
      round_len = 6'd0;
      start_ng  = 1'b0;
      abort_ng  = 1'b0;
`ifdef FLASH_SEQ_REPLAY_EN
      replay    = 1'b0;
      replay_ng = 1'b0;
`endif
      for (int i = 0; i < 64; i++) seg_mem[i] = 2'(i * 5 + 1);
      seg_mem[0] = 2'd2;
      seg_mem[1] = 2'd0;
      seg_mem[2] = 2'd3;

      // Reset state
      repeat (3) step();
      check("rst_seg_idx", 32'(seg_idx), 32'd0);
      check("rst_disp", 32'(disp), 32'd0);
      check("rst_speed", 32'(speed), 32'd0);
      check("rst_load_speed", 32'(load_speed), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      reset_n = 1'b1;
      step();

      // Speed mapping, including the clamp to MAX_LEN
      play(6'd9,  9,  3'd1, "len9");
      play(6'd17, 17, 3'd2, "len17");
      play(6'd33, 33, 3'd4, "len33");
      play(6'd40, 33, 3'd4, "len40_clamped");

      // Reset held for two cycles in the middle of ON, len=5
      round_len = 6'd5;
      start     = 1'b1;
      tcnt      = 0;
      tick      = 1'b0;
      exp_q.push_back(mk(EV_LOAD, {21'd0, 3'd0}));
      exp_q.push_back(mk(EV_LIT, lit_word(6'd0, onehot(seg_mem[0]), 4'd1, 4'd0)));
      step();
      start = 1'b0;
      repeat (4) step();
      reset_n = 1'b0;
      step();
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_disp", 32'(disp), 32'd0);
      check("midrst_seg_idx", 32'(seg_idx), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      step();
      reset_n = 1'b1;
      check("midrst_speed", 32'(speed), 32'd0);
      wait_idle("midrst", 20);

      // Basic playback of {2,0,3}, starting again from index 0
      play(6'd3, 3, 3'd0, "basic");

      // len=0 with start and abort together: start wins, then LOAD and FIN
      round_len = 6'd0;
      start     = 1'b1;
      abort     = 1'b1;
      tcnt      = 0;
      tick      = 1'b0;
      expect_play(0, 3'd0);
      step();
      start = 1'b0;
      abort = 1'b0;
      check("len0_load_speed", 32'(load_speed), 32'd1);
      check("len0_done_early", 32'(done), 32'd0);
      step();
      check("len0_done", 32'(done), 32'd1);
      check("len0_disp", 32'(disp), 32'd0);
      wait_idle("len0", 20);

      // Abort during the OFF phase of index 1, len=4
      round_len = 6'd4;
      start     = 1'b1;
      tcnt      = 0;
      tick      = 1'b0;
      exp_q.push_back(mk(EV_LOAD, {21'd0, 3'd0}));
      exp_q.push_back(mk(EV_LIT, lit_word(6'd0, onehot(seg_mem[0]), 4'd2, 4'd0)));
      exp_q.push_back(mk(EV_LIT, lit_word(6'd1, onehot(seg_mem[1]), 4'd2, 4'd0)));
      step();
      start = 1'b0;
      repeat (21) step();
      check("abort_pre_idx", 32'(seg_idx), 32'd1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_disp", 32'(disp), 32'd0);
      check("abort_seg_idx", 32'(seg_idx), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      repeat (8) step();
      wait_idle("abort", 20);

      // A start while busy is ignored
      round_len = 6'd3;
      start     = 1'b1;
      tcnt      = 0;
      tick      = 1'b0;
      expect_play(3, 3'd0);
      step();
      start = 1'b0;
      repeat (14) step();
      round_len = 6'd9;
      start     = 1'b1;
      step();
      start = 1'b0;
      check("busy_start_seg_idx", 32'(seg_idx), 32'd1);
      check("busy_start_busy", 32'(busy), 32'd1);
      wait_idle("busy_start", 600);

      // No-gap instance: the colour changes directly, with no blank cycle
      round_len = 6'd2;
      start_ng  = 1'b1;
      tcnt      = 0;
      tick      = 1'b0;
      step();
      start_ng = 1'b0;
      done_cnt = 0;
      seen.push_back(disp_ng);
      for (int k = 0; k < 24; k++) begin
         step();
         if (disp_ng !== seen[seen.size() - 1]) seen.push_back(disp_ng);
         if (done_ng === 1'b1) done_cnt++;
      end
      check("nogap_changes", 32'(seen.size()), 32'd4);
      if (seen.size() == 4) begin
         check("nogap_seq0", 32'(seen[0]), 32'h0);
         check("nogap_seq1", 32'(seen[1]), 32'(onehot(seg_mem[0])));
         check("nogap_seq2", 32'(seen[2]), 32'(onehot(seg_mem[1])));
         check("nogap_seq3", 32'(seen[3]), 32'h0);
      end
      check("nogap_done_pulses", 32'(done_cnt), 32'd1);

`ifdef FLASH_SEQ_REPLAY_EN
      // Replay reuses the latched length 2 and ignores round_len=7
      play(6'd2, 2, 3'd0, "replay_first");
      round_len = 6'd7;
      replay    = 1'b1;
      tcnt      = 0;
      tick      = 1'b0;
      expect_play(2, 3'd0);
      step();
      replay = 1'b0;
      wait_idle("replay", 100);
`endif

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
